// File: rtl/hv_video_timing.sv
// Raster timing generator: divides the system clock to the pixel rate and produces
// pixel/line counters, blanking, sync (with per-frame latched centring offsets) and a VBLANK strobe.
module hv_video_timing #(
  parameter int CLK_DIV      = 8,
  parameter int H_TOTAL      = 384,
  parameter int H_VIS        = 256,
  parameter int H_SYNC_START = 296,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 264,
  parameter int V_VIS_START  = 16,
  parameter int V_VIS        = 224,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_LEN   = 8
) (
  input  logic              clk48M,
  input  logic              reset_n,
  input  logic signed [3:0] HOFS,
  input  logic signed [3:0] VOFS,
  output logic              PCLK_EN,
  output logic              PCLK,
  output logic [8:0]        PH,
  output logic [8:0]        PV,
  output logic              HBLK,
  output logic              VBLK,
  output logic              HSYNC_N,
  output logic              VSYNC_N,
  output logic              VBL_IRQ
);

  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]     DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [8:0]        H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0]        V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0]        H_VIS_END = 9'(H_VIS);
  localparam logic [8:0]        V_VIS_BEG = 9'(V_VIS_START);
  localparam logic [8:0]        V_VIS_END = 9'(V_VIS_START + V_VIS);
  localparam logic signed [9:0] HS_START  = 10'(H_SYNC_START);
  localparam logic signed [9:0] HS_LEN    = 10'(H_SYNC_LEN);
  localparam logic signed [9:0] VS_START  = 10'(V_SYNC_START);
  localparam logic signed [9:0] VS_LEN    = 10'(V_SYNC_LEN);

  logic [DW-1:0]     div_q, div_d;
  logic              pclk_en_q, pclk_en_d;
  logic              pclk_q, pclk_d;
  logic [8:0]        ph_q, ph_d;
  logic [8:0]        pv_q, pv_d;
  logic signed [3:0] hofs_q, hofs_d;
  logic signed [3:0] vofs_q, vofs_d;
  logic              hblk_q, hblk_d;
  logic              vblk_q, vblk_d;
  logic              hsync_n_q, hsync_n_d;
  logic              vsync_n_q, vsync_n_d;
  logic              vbl_irq_q, vbl_irq_d;
  logic              frame_start;
  logic signed [9:0] ph_s, pv_s, hs_lo, vs_lo;

  always_comb begin
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    pclk_en_d = (div_d == DIV_LAST);
    pclk_d    = (div_d >= DIV_HALF);

    ph_d = ph_q;
    pv_d = pv_q;
    if (pclk_en_q) begin
      if (ph_q == H_LAST) begin
        ph_d = '0;
        pv_d = (pv_q == V_LAST) ? '0 : pv_q + 9'd1;
      end else begin
        ph_d = ph_q + 9'd1;
      end
    end

    // Offsets only change on the edge that starts a new frame, so sync cannot tear.
    frame_start = pclk_en_q && (ph_d == '0) && (pv_d == '0);
    hofs_d      = frame_start ? HOFS : hofs_q;
    vofs_d      = frame_start ? VOFS : vofs_q;

    // Decodes follow the next counter values so they line up with PH/PV.
    ph_s  = $signed({1'b0, ph_d});
    pv_s  = $signed({1'b0, pv_d});
    hs_lo = HS_START + {{6{hofs_d[3]}}, hofs_d};
    vs_lo = VS_START + {{6{vofs_d[3]}}, vofs_d};

    hblk_d    = (ph_d >= H_VIS_END);
    vblk_d    = (pv_d < V_VIS_BEG) || (pv_d >= V_VIS_END);
    hsync_n_d = !((ph_s >= hs_lo) && (ph_s < hs_lo + HS_LEN));
    vsync_n_d = !((pv_s >= vs_lo) && (pv_s < vs_lo + VS_LEN));
    vbl_irq_d = pclk_en_q && (ph_d == '0) && (pv_d == V_VIS_END);
  end

  always_ff @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      pclk_en_q <= 1'b0;
      pclk_q    <= 1'b0;
      ph_q      <= '0;
      pv_q      <= '0;
      hofs_q    <= '0;
      vofs_q    <= '0;
      hblk_q    <= 1'b0;
      vblk_q    <= 1'b1;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      vbl_irq_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      pclk_en_q <= pclk_en_d;
      pclk_q    <= pclk_d;
      ph_q      <= ph_d;
      pv_q      <= pv_d;
      hofs_q    <= hofs_d;
      vofs_q    <= vofs_d;
      hblk_q    <= hblk_d;
      vblk_q    <= vblk_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      vbl_irq_q <= vbl_irq_d;
    end
  end

  assign PCLK_EN = pclk_en_q;
  assign PCLK    = pclk_q;
  assign PH      = ph_q;
  assign PV      = pv_q;
  assign HBLK    = hblk_q;
  assign VBLK    = vblk_q;
  assign HSYNC_N = hsync_n_q;
  assign VSYNC_N = vsync_n_q;
  assign VBL_IRQ = vbl_irq_q;

endmodule

// File: tb/tb_hv_video_timing.sv
// Directed bench: a default-parameter instance for divider/line timing and a scaled instance
// (short lines and frames) for frame-level behaviour, offsets latching and mid-frame reset.
module tb_hv_video_timing;

  logic clk48M = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk48M = ~clk48M;

  int checks = 0;
  int failures = 0;
  int edges = 0;
  int irq_s_cnt = 0;
  int irq_d_cnt = 0;

  logic signed [3:0] d_hofs = 4'sd0, d_vofs = 4'sd0;
  logic signed [3:0] s_hofs = 4'sd0, s_vofs = 4'sd0;

  logic       d_pclk_en, d_pclk, d_hblk, d_vblk, d_hsync_n, d_vsync_n, d_irq;
  logic [8:0] d_ph, d_pv;
  logic       s_pclk_en, s_pclk, s_hblk, s_vblk, s_hsync_n, s_vsync_n, s_irq;
  logic [8:0] s_ph, s_pv;

  hv_video_timing dut (
    .clk48M(clk48M), .reset_n(reset_n), .HOFS(d_hofs), .VOFS(d_vofs),
    .PCLK_EN(d_pclk_en), .PCLK(d_pclk), .PH(d_ph), .PV(d_pv),
    .HBLK(d_hblk), .VBLK(d_vblk), .HSYNC_N(d_hsync_n), .VSYNC_N(d_vsync_n),
    .VBL_IRQ(d_irq)
  );

  // Scaled raster: 2 clocks/pixel, 48 pixels/line, 48 lines/frame (4608 clocks per frame).
  hv_video_timing #(
    .CLK_DIV(2), .H_TOTAL(48), .H_VIS(32), .H_SYNC_START(37), .H_SYNC_LEN(4),
    .V_TOTAL(48), .V_VIS_START(4), .V_VIS(28), .V_SYNC_START(36), .V_SYNC_LEN(3)
  ) dut_s (
    .clk48M(clk48M), .reset_n(reset_n), .HOFS(s_hofs), .VOFS(s_vofs),
    .PCLK_EN(s_pclk_en), .PCLK(s_pclk), .PH(s_ph), .PV(s_pv),
    .HBLK(s_hblk), .VBLK(s_vblk), .HSYNC_N(s_hsync_n), .VSYNC_N(s_vsync_n),
    .VBL_IRQ(s_irq)
  );

  always @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  always @(posedge clk48M) begin
    if (s_irq) irq_s_cnt <= irq_s_cnt + 1;
    if (d_irq) irq_d_cnt <= irq_d_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int e);
    int guard = 0;
    while (edges < e && guard < 20000) begin
      @(negedge clk48M);
      guard++;
    end
    if (guard >= 20000) begin
      checks++;
      failures++;
      $display("FAIL run_to observed=%0d expected=%0d", edges, e);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_d_pclk_en"}, d_pclk_en, 0);
    chk({tag, "_d_pclk"}, d_pclk, 0);
    chk({tag, "_d_ph"}, d_ph, 0);
    chk({tag, "_d_pv"}, d_pv, 0);
    chk({tag, "_d_hblk"}, d_hblk, 0);
    chk({tag, "_d_vblk"}, d_vblk, 1);
    chk({tag, "_d_hsync_n"}, d_hsync_n, 1);
    chk({tag, "_d_vsync_n"}, d_vsync_n, 1);
    chk({tag, "_d_irq"}, d_irq, 0);
    chk({tag, "_s_ph"}, s_ph, 0);
    chk({tag, "_s_pv"}, s_pv, 0);
    chk({tag, "_s_vblk"}, s_vblk, 1);
    chk({tag, "_s_hblk"}, s_hblk, 0);
    chk({tag, "_s_vsync_n"}, s_vsync_n, 1);
    chk({tag, "_s_irq"}, s_irq, 0);
    chk({tag, "_s_pclk_en"}, s_pclk_en, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk48M);
    chk_reset_vals("rst");
    reset_n = 1'b1;

    // T1: divider on the default instance
    for (int i = 1; i <= 16; i++) begin
      run_to(i);
      chk($sformatf("pclk_en_e%0d", i), d_pclk_en, (i % 8 == 7) ? 1 : 0);
      chk($sformatf("pclk_e%0d", i), d_pclk, (i % 8 >= 4) ? 1 : 0);
      if (i == 8) chk("ph_after_first_pixel", d_ph, 1);
    end

    // Scaled instance: vertical blank edges, horizontal blank edge
    run_to(288);  chk("s_vblk_pv3", s_vblk, 1);
    run_to(384);  chk("s_vblk_pv4", s_vblk, 0);
    run_to(446);  chk("s_hblk_ph31", s_hblk, 0);
    run_to(448);  chk("s_hblk_ph32", s_hblk, 1);

    // T2: default line timing, blanking and nominal hsync
    run_to(2040); chk("d_ph255", d_ph, 255); chk("d_hblk_255", d_hblk, 0);
    run_to(2048); chk("d_ph256", d_ph, 256); chk("d_hblk_256", d_hblk, 1);
    run_to(2360); chk("d_hs_295", d_hsync_n, 1);
    run_to(2368); chk("d_hs_296", d_hsync_n, 0);
    run_to(2616); chk("d_hs_327", d_hsync_n, 0);
    run_to(2624); chk("d_hs_328", d_hsync_n, 1);
    run_to(3064); chk("d_ph383", d_ph, 383); chk("d_pv_l0", d_pv, 0); chk("d_hblk_383", d_hblk, 1);

    // T3 on the scaled instance: last visible line and the VBLANK strobe
    run_to(3070); chk("s_vblk_pv31", s_vblk, 0);
    run_to(3071); chk("s_irq_before", s_irq, 0);
    run_to(3072);
    chk("d_ph_wrap", d_ph, 0); chk("d_pv_wrap", d_pv, 1); chk("d_hblk_wrap", d_hblk, 0);
    chk("s_irq_pulse", s_irq, 1); chk("s_pv32", s_pv, 32); chk("s_ph0", s_ph, 0);
    chk("s_vblk_pv32", s_vblk, 1);
    run_to(3073); chk("s_irq_after", s_irq, 0);

    // T4/T5 frame 0: nominal sync positions
    run_to(3240); chk("s_hs_f0_36", s_hsync_n, 1);
    run_to(3242); chk("s_hs_f0_37", s_hsync_n, 0);
    run_to(3248); chk("s_hs_f0_40", s_hsync_n, 0);
    run_to(3250); chk("s_hs_f0_41", s_hsync_n, 1);
    run_to(3360); chk("s_vs_f0_35", s_vsync_n, 1);
    run_to(3456); chk("s_vs_f0_36", s_vsync_n, 0);
    run_to(3742); chk("s_vs_f0_38", s_vsync_n, 0);
    run_to(3744); chk("s_vs_f0_39", s_vsync_n, 1);

    // New offsets mid-frame must not move sync until the next frame
    run_to(3800);
    s_hofs = -4'sd3;
    s_vofs = 4'sd7;
    run_to(3912); chk("s_hs_hold_36", s_hsync_n, 1);
    run_to(3914); chk("s_hs_hold_37", s_hsync_n, 0);
    run_to(4128); chk("s_vs_hold_43", s_vsync_n, 1);

    run_to(4607); chk("s_ph_end", s_ph, 47); chk("s_pv_end", s_pv, 47);
    run_to(4608);
    chk("s_ph_frame", s_ph, 0); chk("s_pv_frame", s_pv, 0); chk("s_vblk_frame", s_vblk, 1);
    chk("s_irq_cnt_f0", irq_s_cnt, 1);

    // Frame 1: hofs=-3 shifts hsync to 34..37, vofs=+7 shifts vsync to 43..45
    run_to(4770); chk("s_hs_f1_33", s_hsync_n, 1);
    run_to(4772); chk("s_hs_f1_34", s_hsync_n, 0);
    run_to(4778); chk("s_hs_f1_37", s_hsync_n, 0);
    run_to(4780); chk("s_hs_f1_38", s_hsync_n, 1);
    run_to(8640); chk("s_vs_f1_42", s_vsync_n, 1);
    run_to(8736); chk("s_vs_f1_43", s_vsync_n, 0);
    run_to(9022); chk("s_vs_f1_45", s_vsync_n, 0);
    run_to(9024); chk("s_vs_f1_46", s_vsync_n, 1);
    chk("s_irq_cnt_f1", irq_s_cnt, 2);

    // T6: asynchronous reset mid-frame (scaled PH=20, PV=32 of frame 2)
    run_to(12328);
    chk("s_ph_pre_rst", s_ph, 20); chk("s_pv_pre_rst", s_pv, 32);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    chk("s_irq_cnt_f2", irq_s_cnt, 3);
    chk("d_irq_cnt", irq_d_cnt, 0);
    @(negedge clk48M);
    reset_n = 1'b1;
    run_to(1);   chk("rs_ph0", s_ph, 0); chk("rs_pclk_en", s_pclk_en, 1);
    run_to(2);   chk("rs_ph1", s_ph, 1); chk("rs_pv0", s_pv, 0);
    run_to(164); chk("rs_hs_34", s_hsync_n, 1);
    run_to(170); chk("rs_hs_37", s_hsync_n, 0); chk("rs_pv1", s_pv, 1);
    chk("rs_irq_cnt", irq_s_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
